// File: rtl/led_pwm_bank.sv
// led_pwm_bank: N-channel prescaled PWM LED controller behind an spi_slave register window
// Ports: clk/reset (sync, active-high); we/re/addr/wdat register bus in; rdat/hit read mux out;
//        pwm_out registered PWM per channel; frame_stb pulses after each frame wrap; busy = any cur!=target.
module led_pwm_bank #(
  parameter int NCH = 3,
  parameter int PWM_W = 8,
  parameter int PRESC_W = 16,
  parameter logic [6:0] BASE_ADDR = 7'h10
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic re,
  input  logic [6:0] addr,
  input  logic [31:0] wdat,
  output logic [31:0] rdat,
  output logic hit,
  output logic [NCH-1:0] pwm_out,
  output logic frame_stb,
  output logic busy
);
  localparam logic [6:0] NREG = 7'(3 + 2 * NCH);
  logic [2:0] ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pre_cnt_q, pre_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q [NCH];
  logic [PWM_W-1:0] duty_d [NCH];
  logic [PWM_W-1:0] cur_q [NCH];
  logic [PWM_W-1:0] cur_d [NCH];
  logic [NCH-1:0] pwm_out_q, pwm_out_d, stat;
  logic frame_stb_q, frame_stb_d;
  logic [6:0] off;
  logic wr, en, fade, inv, tick, wrap, unused;
  assign unused = ^{re, wdat};
  assign en = ctrl_q[0];
  assign fade = ctrl_q[1];
  assign inv = ctrl_q[2];
  assign off = addr - BASE_ADDR;
  assign hit = (addr >= BASE_ADDR) && (off < NREG);
  assign wr = we & hit;
  assign tick = en && (pre_cnt_q == presc_q);
  assign wrap = tick && (&pwm_cnt_q);
  assign pwm_out = pwm_out_q;
  assign frame_stb = frame_stb_q;
  assign busy = |stat;
  always_comb begin
    ctrl_d = (wr && off == 7'd0) ? wdat[2:0] : ctrl_q;
    presc_d = (wr && off == 7'd1) ? wdat[PRESC_W-1:0] : presc_q;
    pre_cnt_d = (!en || (wr && off == 7'd1) || tick) ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = !en ? '0 : pwm_cnt_q + PWM_W'(tick);
    frame_stb_d = wrap;
    for (int i = 0; i < NCH; i++) begin
      duty_d[i] = (wr && off == 7'(2 + i)) ? wdat[PWM_W-1:0] : duty_q[i];
      // duty_q here is the pre-write value, so a DUTY write landing on the wrap edge waits a frame
      cur_d[i] = !en ? duty_q[i] :
                 !wrap ? cur_q[i] :
                 !fade ? duty_q[i] :
                 (cur_q[i] < duty_q[i]) ? cur_q[i] + 1'b1 :
                 (cur_q[i] > duty_q[i]) ? cur_q[i] - 1'b1 : cur_q[i];
      pwm_out_d[i] = en & ((pwm_cnt_q < cur_q[i]) ^ inv);
      stat[i] = en & (cur_q[i] != duty_q[i]);
    end
  end
  always_comb begin
    rdat = '0;
    if (hit) begin
      if (off == 7'd0) rdat[2:0] = ctrl_q;
      if (off == 7'd1) rdat[PRESC_W-1:0] = presc_q;
      if (off == 7'(2 + NCH)) rdat[NCH-1:0] = stat;
      for (int i = 0; i < NCH; i++) begin
        if (off == 7'(2 + i)) rdat[PWM_W-1:0] = duty_q[i];
        if (off == 7'(3 + NCH + i)) rdat[PWM_W-1:0] = cur_q[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 3'b001;
      presc_q <= '0;
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      duty_q <= '{default: '0};
      cur_q <= '{default: '0};
      pwm_out_q <= '0;
      frame_stb_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      presc_q <= presc_d;
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q <= duty_d;
      cur_q <= cur_d;
      pwm_out_q <= pwm_out_d;
      frame_stb_q <= frame_stb_d;
    end
  end
endmodule

// File: tb/tb_led_pwm_bank.sv
// tb_led_pwm_bank: directed self-checking bench for led_pwm_bank (NCH=3, PWM_W=8, BASE 0x10)
module tb_led_pwm_bank;
  logic clk, reset, we, re, hit, frame_stb, busy;
  logic [6:0] addr;
  logic [31:0] wdat, rdat, d;
  logic [2:0] pwm_out;
  int total = 0, pass = 0, h, s, n;
  localparam logic [6:0] A_CTRL = 7'h10, A_PRESC = 7'h11, A_DUTY0 = 7'h12, A_DUTY1 = 7'h13,
    A_DUTY2 = 7'h14, A_STAT = 7'h15, A_CUR0 = 7'h16, A_CUR1 = 7'h17, A_CUR2 = 7'h18;
  led_pwm_bank dut (.clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdat(wdat),
    .rdat(rdat), .hit(hit), .pwm_out(pwm_out), .frame_stb(frame_stb), .busy(busy));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] v);
    addr = a;
    wdat = v;
    we = 1;
    @(negedge clk);
    we = 0;
  endtask
  task automatic rd(input logic [6:0] a, output logic [31:0] v);
    addr = a;
    re = 1;
    #1;
    v = rdat;
    re = 0;
  endtask
  task automatic wait_stb();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_stb && i < 3000);
    chk("stb_seen", 32'(frame_stb), 1);
  endtask
  task automatic count_to_stb(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_stb && c < 5000);
  endtask
  task automatic measure(input int ch, input int len, output int hi, output int st);
    hi = 0;
    st = 0;
    for (int i = 0; i < len; i++) begin
      hi += int'(pwm_out[ch]);
      st += int'(frame_stb);
      @(negedge clk);
    end
  endtask
  initial begin
    reset = 1; we = 0; re = 0; addr = 0; wdat = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    rd(A_CTRL, d); chk("rst_ctrl", d, 1);
    rd(A_PRESC, d); chk("rst_presc", d, 0);
    rd(A_DUTY0, d); chk("rst_duty0", d, 0);
    rd(A_CUR0, d); chk("rst_cur0", d, 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_stb", 32'(frame_stb), 0);
    chk("rst_busy", 32'(busy), 0);
    wr(A_DUTY0, 64);
    wait_stb(); wait_stb();
    measure(0, 256, h, s);
    chk("t1_high64", h, 64);
    chk("t1_stb_per_frame", s, 1);
    wr(A_PRESC, 3);
    wr(A_DUTY1, 128);
    wait_stb(); wait_stb();
    measure(1, 1024, h, s);
    chk("t2_high512", h, 512);
    chk("t2_stb_per_1024", s, 1);
    chk("t2_align", 32'(frame_stb), 1);
    @(negedge clk);
    wr(A_PRESC, 3);
    count_to_stb(n);
    chk("t2_presc_restart", n, 1024);
    wr(A_PRESC, 0);
    wait_stb();
    repeat (255) @(negedge clk);
    wr(A_DUTY2, 200);
    chk("t3_wrap_edge", 32'(frame_stb), 1);
    rd(A_CUR2, d); chk("t3_cur2_old", d, 0);
    rd(A_DUTY2, d); chk("t3_duty2", d, 200);
    wait_stb();
    rd(A_CUR2, d); chk("t3_cur2_new", d, 200);
    wr(A_DUTY0, 10);
    wait_stb();
    rd(A_CUR0, d); chk("t4_cur10", d, 10);
    wr(A_CTRL, 3);
    wr(A_DUTY0, 13);
    wait_stb();
    rd(A_CUR0, d); chk("t4_cur11", d, 11);
    rd(A_STAT, d); chk("t4_stat_busy", d, 1);
    chk("t4_busy1", 32'(busy), 1);
    wait_stb();
    rd(A_CUR0, d); chk("t4_cur12", d, 12);
    wait_stb();
    rd(A_CUR0, d); chk("t4_cur13", d, 13);
    rd(A_STAT, d); chk("t4_stat_clear", d, 0);
    chk("t4_busy0", 32'(busy), 0);
    wr(A_CTRL, 5);
    wr(A_DUTY0, 0);
    wait_stb(); wait_stb();
    measure(0, 256, h, s);
    chk("t5_inv_const1", h, 256);
    wr(A_CTRL, 4);
    @(negedge clk);
    chk("t5_en0_pwm", 32'(pwm_out), 0);
    wr(A_DUTY1, 77);
    @(negedge clk);
    rd(A_CUR1, d); chk("t5_cur_follows", d, 77);
    rd(A_STAT, d); chk("t5_stat0", d, 0);
    chk("t5_busy0", 32'(busy), 0);
    measure(0, 300, h, s);
    chk("t5_off_high", h, 0);
    chk("t5_off_stb", s, 0);
    wr(A_CTRL, 1);
    count_to_stb(n);
    chk("t5_first_wrap", n, 256);
    measure(1, 256, h, s);
    chk("t5_high77", h, 77);
    rd(7'h05, d); chk("t6_unmapped_rdat", d, 0); chk("t6_unmapped_hit", 32'(hit), 0);
    rd(7'h00, d); chk("t6_id_rdat", d, 0); chk("t6_id_hit", 32'(hit), 0);
    rd(7'h19, d); chk("t6_past_end_hit", 32'(hit), 0);
    rd(A_CUR2, d); chk("t6_last_hit", 32'(hit), 1);
    wr(A_CUR0, 32'h55);
    rd(A_CUR0, d); chk("t6_cur_ro", d, 0);
    rd(A_DUTY0, d); chk("t6_duty0_kept", d, 0);
    wr(A_STAT, 32'hff);
    rd(A_STAT, d); chk("t6_stat_ro", d, 0);
    wr(7'h05, 32'h6);
    rd(A_CTRL, d); chk("t6_ctrl_kept", d, 1);
    wr(A_DUTY2, 32'h1ff);
    rd(A_DUTY2, d); chk("t6_duty_trunc", d, 32'hff);
    wr(A_PRESC, 32'h12345);
    rd(A_PRESC, d); chk("t6_presc_trunc", d, 32'h2345);
    wr(A_CTRL, 7);
    reset = 1;
    @(negedge clk);
    rd(A_CTRL, d); chk("t7_ctrl", d, 1);
    rd(A_PRESC, d); chk("t7_presc", d, 0);
    rd(A_DUTY2, d); chk("t7_duty2", d, 0);
    rd(A_CUR2, d); chk("t7_cur2", d, 0);
    chk("t7_pwm", 32'(pwm_out), 0);
    chk("t7_stb", 32'(frame_stb), 0);
    reset = 0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
